pixel_write_queue: RTL

//  Downstream of the line animator. Accepts a stream of pixel writes
//  (x, y, color) and drops writes that fall off-screen. Also drops

---
 rtl/pixel_write_queue_if.sv | 28 ++
 rtl/pixel_write_queue.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/pixel_write_queue_if.sv
// Bundles the pixel input handshake and the framebuffer write port of
// pixel_write_queue. The queue is the slave side; the producer/memory
// environment drives the master side.
interface pixel_write_queue_if #(
  parameter int ADDR_W = 19
);
  // pixel input stream
  logic              in_valid;
  logic [10:0]       in_x;
  logic [10:0]       in_y;
  logic              in_color;
  logic              in_ready;
  // framebuffer write port
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_data;
  logic              wr_ack;

  modport slave (
    input  in_valid, in_x, in_y, in_color, wr_ack,
    output in_ready, wr_en, wr_addr, wr_data
  );

  modport master (
    output in_valid, in_x, in_y, in_color, wr_ack,
    input  in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/pixel_write_queue.sv
// Pixel write queue: clips off-screen pixels, drops back-to-back duplicate
// pixels, converts survivors to linear framebuffer addresses and queues them
// in a show-ahead FIFO that drains into a stallable framebuffer write port.
module pixel_write_queue #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int ADDR_W = 19,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  pixel_write_queue_if.slave       bus,
  output logic [15:0]              drop_count,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [10:0]       WIDTH_C  = 11'(WIDTH);
  localparam logic [10:0]       HEIGHT_C = 11'(HEIGHT);
  localparam logic [ADDR_W-1:0] WIDTH_A  = ADDR_W'(WIDTH);
  localparam logic [CW:0]       DEPTH_C  = (CW + 1)'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              color;
  } entry_t;

  // S1 stage
  logic        s1_valid_q;
  logic [10:0] s1_x_q;
  logic [10:0] s1_y_q;
  logic        s1_color_q;
  logic        s1_clip_q;
  logic        s1_dup_q;

  // last accepted pixel, used for duplicate suppression
  logic        last_valid_q;
  logic [22:0] last_q;

  // FIFO storage and bookkeeping
  entry_t      mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [15:0]   drop_q;
  logic [15:0]   drop_d;

  logic          accept;
  logic          push;
  logic          drop;
  logic          pop;
  logic [22:0]   in_pix;
  logic [CW:0]   occupancy;
  entry_t        push_entry;

  assign in_pix    = {bus.in_x, bus.in_y, bus.in_color};
  assign accept    = bus.in_valid && bus.in_ready;

  // S1 occupancy is counted against the FIFO so a push can never overflow.
  assign occupancy    = {1'b0, count_q} + (CW + 1)'(s1_valid_q);
  assign bus.in_ready = occupancy < DEPTH_C;

  assign push = s1_valid_q && !s1_clip_q && !s1_dup_q;
  assign drop = s1_valid_q && (s1_clip_q || s1_dup_q);
  assign pop  = (count_q != '0) && bus.wr_ack;

  assign push_entry.addr  = ADDR_W'(s1_y_q) * WIDTH_A + ADDR_W'(s1_x_q);
  assign push_entry.color = s1_color_q;

  // show-ahead head of queue
  assign bus.wr_en   = (count_q != '0);
  assign bus.wr_addr = mem_q[rd_ptr_q].addr;
  assign bus.wr_data = mem_q[rd_ptr_q].color;

  assign fifo_count = count_q;
  assign drop_count = drop_q;

  // next occupancy and saturating drop counter
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
    drop_d = drop_q;
    if (drop && (drop_q != '1)) begin
      drop_d = drop_q + 16'd1;
    end
  end

  // S1 capture with clip/dup classification; last pixel tracks every accept
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s1_x_q       <= '0;
      s1_y_q       <= '0;
      s1_color_q   <= 1'b0;
      s1_clip_q    <= 1'b0;
      s1_dup_q     <= 1'b0;
      last_valid_q <= 1'b0;
      last_q       <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_x_q       <= bus.in_x;
        s1_y_q       <= bus.in_y;
        s1_color_q   <= bus.in_color;
        s1_clip_q    <= (bus.in_x >= WIDTH_C) || (bus.in_y >= HEIGHT_C);
        s1_dup_q     <= last_valid_q && (in_pix == last_q);
        last_valid_q <= 1'b1;
        last_q       <= in_pix;
      end
    end
  end

  // FIFO storage, pointers, occupancy and drop counter
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_entry;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

endmodule
